// File: rtl/spram_fifo_pkg.sv
// Shared types and index helpers for the single-port-RAM FIFO.
// Provides instruction bit positions, arbiter priority type and count width.
package spram_fifo_pkg;

    typedef enum logic {
        PRIO_READ  = 1'b0,
        PRIO_WRITE = 1'b1
    } prio_e;

    function automatic int inst_we_bit(input int dw);
        return dw + 1;
    endfunction

    function automatic int inst_re_bit(input int dw);
        return dw;
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/spram_sp.sv
// Single-port RAM, synchronous read, no reset on storage or output.
// Ports: clk, en, we, addr, din, dout (updated only on read access).
module spram_sp #(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= din;
            else    dout      <= mem[addr];
        end
    end

endmodule

// File: rtl/spram_fifo_arb.sv
// FIFO over one single-port RAM, fed by {WE,RE,DI} instruction words,
// with fair write/read arbitration, occupancy count and threshold flags.
// Ports: clk, rst (async high), inst, wr_ack, rd_ack, DO, read_valid,
//   full, empty, almost_full, almost_empty, count.
// Optional (SPFIFO_ERR_FLAGS_EN): ovf_err, udf_err sticky flags, err_clr.
module spram_fifo_arb
    import spram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_MARGIN  = 1,
    parameter int AE_MARGIN  = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_WIDTH+1:0]        inst,
    output logic                         wr_ack,
    output logic                         rd_ack,
    output logic [DATA_WIDTH-1:0]        DO,
    output logic                         read_valid,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
`ifdef SPFIFO_ERR_FLAGS_EN
    output logic                         ovf_err,
    output logic                         udf_err,
    input  logic                         err_clr,
`endif
    output logic [cnt_width(DEPTH)-1:0]  count
);

    localparam int AW     = $clog2(DEPTH);
    localparam int CW     = cnt_width(DEPTH);
    localparam int WE_BIT = inst_we_bit(DATA_WIDTH);
    localparam int RE_BIT = inst_re_bit(DATA_WIDTH);

    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C   = CW'(DEPTH - AF_MARGIN);
    localparam logic [CW-1:0] AE_C   = CW'(AE_MARGIN);

    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         cnt;
    prio_e                 prio;
    logic                  rv_q;
    logic [DATA_WIDTH-1:0] do_q;
    logic [DATA_WIDTH-1:0] ram_dout;

    logic we_req;
    logic re_req;
    logic wr_elig;
    logic rd_elig;
    logic conflict;

    // Flags come from the count register only.
    assign full         = (cnt == FULL_C);
    assign empty        = (cnt == '0);
    assign almost_full  = (cnt >= AF_C);
    assign almost_empty = (cnt <= AE_C);
    assign count        = cnt;
    assign read_valid   = rv_q;

    // RAM output is live only on the cycle after a read; otherwise
    // present the last delivered word, which is reset to zero.
    assign DO = rv_q ? ram_dout : do_q;

    always_comb begin
        we_req   = inst[WE_BIT];
        re_req   = inst[RE_BIT];
        wr_elig  = we_req & ~full;
        rd_elig  = re_req & ~empty;
        conflict = wr_elig & rd_elig;
        wr_ack   = wr_elig & (~rd_elig | (prio == PRIO_WRITE));
        rd_ack   = rd_elig & (~wr_elig | (prio == PRIO_READ));
    end

    spram_sp #(
        .DW (DATA_WIDTH),
        .AW (AW)
    ) u_ram (
        .clk  (clk),
        .en   (wr_ack | rd_ack),
        .we   (wr_ack),
        .addr (wr_ack ? wr_ptr : rd_ptr),
        .din  (inst[DATA_WIDTH-1:0]),
        .dout (ram_dout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            prio   <= PRIO_READ;
            rv_q   <= 1'b0;
            do_q   <= '0;
        end else begin
            if (wr_ack) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ack) rd_ptr <= rd_ptr + 1'b1;
            if (wr_ack)      cnt <= cnt + 1'b1;
            else if (rd_ack) cnt <= cnt - 1'b1;
            // The side just served yields on the next conflict.
            if (conflict)
                prio <= (prio == PRIO_READ) ? PRIO_WRITE : PRIO_READ;
            rv_q <= rd_ack;
            if (rv_q) do_q <= ram_dout;
        end
    end

`ifdef SPFIFO_ERR_FLAGS_EN
    // A new violation outranks a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
        end else begin
            if (we_req & full)  ovf_err <= 1'b1;
            else if (err_clr)   ovf_err <= 1'b0;
            if (re_req & empty) udf_err <= 1'b1;
            else if (err_clr)   udf_err <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_spram_fifo_arb.sv
// Self-checking bench for spram_fifo_arb (DATA_WIDTH=8, DEPTH=8, AF=AE=1).
// Vector table, directed corner sequences and random traffic vs a queue model.
module tb_spram_fifo_arb;

    localparam int DW = 8;
    localparam int DP = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW+1:0] inst = '0;
    logic          clr = 1'b0;
    logic          wr_ack, rd_ack, read_valid;
    logic          full, empty, almost_full, almost_empty;
    logic [DW-1:0] DO;
    logic [3:0]    count;
`ifdef SPFIFO_ERR_FLAGS_EN
    logic          ovf_err, udf_err;
`endif

    always #5 clk = ~clk;

    spram_fifo_arb #(
        .DATA_WIDTH (DW),
        .DEPTH      (DP),
        .AF_MARGIN  (1),
        .AE_MARGIN  (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .inst         (inst),
        .wr_ack       (wr_ack),
        .rd_ack       (rd_ack),
        .DO           (DO),
        .read_valid   (read_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
`ifdef SPFIFO_ERR_FLAGS_EN
        .ovf_err      (ovf_err),
        .udf_err      (udf_err),
        .err_clr      (clr),
`endif
        .count        (count)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: a data queue plus the fairness bit
    // (0 = read wins the next conflict, 1 = write wins).
    logic [DW-1:0] q[$];
    bit            m_wprio;
    bit            m_rv;
    logic [DW-1:0] m_do;
    bit            m_ovf, m_udf;

    function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endfunction

    function automatic void model_reset();
        q.delete();
        m_wprio = 1'b0;
        m_rv    = 1'b0;
        m_do    = '0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
    endfunction

    task automatic do_reset();
        rst  = 1'b1;
        inst = '0;
        clr  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        rst = 1'b0;
    endtask

    // One clock: drive at negedge, check against model, advance model.
    task automatic step(input bit we, input bit re, input logic [DW-1:0] di,
                        output bit aw, output bit ar, output int acnt,
                        output bit arv, output logic [DW-1:0] ado);
        bit wel, rel, mw, mr;
        int sz;
        inst = {we, re, di};
        #1;
        sz  = q.size();
        wel = we && (sz < DP);
        rel = re && (sz > 0);
        mw  = wel && (!rel || m_wprio);
        mr  = rel && (!wel || !m_wprio);
        chk("wr_ack", wr_ack, mw);
        chk("rd_ack", rd_ack, mr);
        chk("count", count, sz);
        chk("full", full, sz == DP);
        chk("empty", empty, sz == 0);
        chk("almost_full", almost_full, sz >= DP - 1);
        chk("almost_empty", almost_empty, sz <= 1);
        chk("read_valid", read_valid, m_rv);
        chk("DO", DO, m_do);
`ifdef SPFIFO_ERR_FLAGS_EN
        chk("ovf_err", ovf_err, m_ovf);
        chk("udf_err", udf_err, m_udf);
`endif
        aw   = wr_ack;
        ar   = rd_ack;
        acnt = int'(count);
        arv  = read_valid;
        ado  = DO;
        @(posedge clk);
        if (we && sz == DP) m_ovf = 1'b1;
        else if (clr)       m_ovf = 1'b0;
        if (re && sz == 0)  m_udf = 1'b1;
        else if (clr)       m_udf = 1'b0;
        if (wel && rel) m_wprio = !m_wprio;
        if (mw) q.push_back(di);
        m_rv = mr;
        if (mr) m_do = q.pop_front();
        @(negedge clk);
    endtask

    typedef struct {
        bit            we;
        bit            re;
        logic [DW-1:0] di;
        bit            ew;
        bit            er;
        int            ecnt;
        bit            erv;
        logic [DW-1:0] edo;
    } vec_t;

    vec_t vt[11];

    initial begin
        bit            aw, ar, rv;
        int            c;
        logic [DW-1:0] d, wd;

        vt[0]  = '{1, 0, 8'hA5, 1, 0, 0, 0, 8'h00};
        vt[1]  = '{1, 0, 8'h3C, 1, 0, 1, 0, 8'h00};
        vt[2]  = '{1, 0, 8'hFF, 1, 0, 2, 0, 8'h00};
        vt[3]  = '{0, 1, 8'h00, 0, 1, 3, 0, 8'h00};
        vt[4]  = '{0, 1, 8'h00, 0, 1, 2, 1, 8'hA5};
        vt[5]  = '{0, 1, 8'h00, 0, 1, 1, 1, 8'h3C};
        vt[6]  = '{0, 0, 8'h00, 0, 0, 0, 1, 8'hFF};
        vt[7]  = '{0, 1, 8'h00, 0, 0, 0, 0, 8'hFF};
        vt[8]  = '{1, 1, 8'h11, 1, 0, 0, 0, 8'hFF};
        vt[9]  = '{0, 1, 8'h00, 0, 1, 1, 0, 8'hFF};
        vt[10] = '{0, 0, 8'h00, 0, 0, 0, 1, 8'h11};

        model_reset();
        @(negedge clk);
        do_reset();

        // Basic write/read order, latency, empty blocking, no fall-through.
        for (int i = 0; i < 11; i++) begin
            step(vt[i].we, vt[i].re, vt[i].di, aw, ar, c, rv, d);
            chk($sformatf("v%0d_wack", i), aw, vt[i].ew);
            chk($sformatf("v%0d_rack", i), ar, vt[i].er);
            chk($sformatf("v%0d_cnt", i), c, vt[i].ecnt);
            chk($sformatf("v%0d_rv", i), rv, vt[i].erv);
            chk($sformatf("v%0d_do", i), d, vt[i].edo);
        end

        // Fill to full, blocked write, then held WE+RE at full.
        do_reset();
        for (int i = 0; i < DP; i++)
            step(1, 0, 8'(8'h40 + i), aw, ar, c, rv, d);
        chk("fill_full", full, 1);
        step(1, 0, 8'h99, aw, ar, c, rv, d);
        chk("full_wr_blocked", aw, 0);
        step(1, 1, 8'h99, aw, ar, c, rv, d);
        chk("full_rd_first", ar, 1);
        chk("full_wr_wait", aw, 0);
        chk("full_cnt8", c, 8);
        step(1, 0, 8'h99, aw, ar, c, rv, d);
        chk("held_wr_acked", aw, 1);
        chk("held_cnt7", c, 7);
        chk("held_rv", rv, 1);
        chk("held_do", d, 8'h40);
        step(0, 0, 8'h00, aw, ar, c, rv, d);
        chk("refill_cnt8", c, 8);

        // Sustained conflict alternates R,W,R,W from reset priority.
        do_reset();
        for (int i = 0; i < 4; i++)
            step(1, 0, 8'(8'h80 + i), aw, ar, c, rv, d);
        wd = 8'hC0;
        for (int i = 0; i < 6; i++) begin
            step(1, 1, wd, aw, ar, c, rv, d);
            chk($sformatf("alt%0d_r", i), ar, (i % 2) == 0);
            chk($sformatf("alt%0d_w", i), aw, (i % 2) == 1);
            if (aw) wd = wd + 8'h1;
        end
        while (q.size() > 0)
            step(0, 1, 8'h00, aw, ar, c, rv, d);
        step(0, 0, 8'h00, aw, ar, c, rv, d);

        // Pointer wrap with alternating write/read pairs.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 8'($urandom), aw, ar, c, rv, d);
            step(0, 1, 8'h00, aw, ar, c, rv, d);
        end
        step(0, 0, 8'h00, aw, ar, c, rv, d);
        chk("wrap_empty", empty, 1);
        chk("wrap_cnt0", count, 0);

        // Reset while a read result is due.
        do_reset();
        step(1, 0, 8'h22, aw, ar, c, rv, d);
        step(1, 0, 8'h33, aw, ar, c, rv, d);
        step(0, 1, 8'h00, aw, ar, c, rv, d);
        chk("pre_rst_rv", read_valid, 1);
        rst  = 1'b1;
        inst = '0;
        #1;
        chk("rst_rv", read_valid, 0);
        chk("rst_cnt", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_do", DO, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(1, 0, 8'h11, aw, ar, c, rv, d);
        step(0, 1, 8'h00, aw, ar, c, rv, d);
        step(0, 0, 8'h00, aw, ar, c, rv, d);
        chk("post_rst_rv", rv, 1);
        chk("post_rst_do", d, 8'h11);

`ifdef SPFIFO_ERR_FLAGS_EN
        do_reset();
        step(0, 1, 8'h00, aw, ar, c, rv, d);
        chk("udf_set", udf_err, 1);
        step(0, 0, 8'h00, aw, ar, c, rv, d);
        chk("udf_sticky", udf_err, 1);
        for (int i = 0; i < DP; i++)
            step(1, 0, 8'(i), aw, ar, c, rv, d);
        step(1, 0, 8'h77, aw, ar, c, rv, d);
        chk("ovf_set", ovf_err, 1);
        clr = 1'b1;
        step(0, 0, 8'h00, aw, ar, c, rv, d);
        chk("ovf_clr", ovf_err, 0);
        chk("udf_clr", udf_err, 0);
        step(1, 0, 8'h77, aw, ar, c, rv, d);
        chk("ovf_set_beats_clr", ovf_err, 1);
        clr = 1'b0;
`endif

        // Random traffic with phases biased toward filling and draining.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            bit pf;
            pf = ((i / 40) % 2) == 0;
            step($urandom_range(0, 99) < (pf ? 75 : 30),
                 $urandom_range(0, 99) < (pf ? 30 : 75),
                 8'($urandom), aw, ar, c, rv, d);
`ifdef SPFIFO_ERR_FLAGS_EN
            clr = ($urandom_range(0, 9) == 0);
`endif
        end
        clr = 1'b0;
        step(0, 0, 8'h00, aw, ar, c, rv, d);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
